// File: rtl/lc3b_pmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b types: word, memory band, line index and
//               responder FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_memband;

    localparam int PMEM_DEPTH_LOG2_DEFAULT = 12;
    localparam int PMEM_CNT_W              = 8;

    // Sized for the default line count; other depths use DEPTH_LOG2 directly
    typedef logic [PMEM_DEPTH_LOG2_DEFAULT-1:0] lc3b_line_index;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_pmem_state;

endpackage
`default_nettype wire

// File: rtl/lc3b_pmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_pmem_responder_if
// Description : Cache-side physical memory bus (line read/write handshake).
// Revision    : 1.0  initial release
// ============================================================================
interface lc3b_pmem_responder_if;
    import lc3b_types::*;

    logic        pmem_read;
    logic        pmem_write;
    lc3b_word    pmem_address;
    lc3b_memband pmem_wdata;
    lc3b_memband pmem_rdata;
    logic        pmem_resp;
    logic        pmem_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, pmem_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, pmem_err
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_pmem_array.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_pmem_array
// Description : DEPTH x 128-bit single-port line store, synchronous write,
//               asynchronous read captured by the responder's output register.
// Revision    : 1.0  initial release
// ============================================================================
module lc3b_pmem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  lc3b_memband           wdata,
    output lc3b_memband           rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Contents start at zero and are deliberately untouched by reset
    lc3b_memband mem_q [DEPTH] = '{default: '0};

    // Line commit on the write strobe
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
    end

    assign rdata = mem_q[index];

endmodule
`default_nettype wire

// File: rtl/lc3b_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_pmem_responder
// Description : Fixed-latency physical memory responder for the LC-3b cache
//               hierarchy. One pmem_resp pulse LATENCY cycles after request.
// Revision    : 1.0  initial release
// ============================================================================
module lc3b_pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3b_pmem_responder_if.slave  pmem
);
    localparam logic [PMEM_CNT_W-1:0] CNT_LOAD = PMEM_CNT_W'(LATENCY - 2);

    lc3b_pmem_state          state_q, state_d;
    logic [PMEM_CNT_W-1:0]   cnt_q, cnt_d;
    lc3b_word                addr_q, addr_d;
    lc3b_memband             wdata_q, wdata_d;
    logic                    write_op_q, write_op_d;
    lc3b_memband             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    arr_we;
    lc3b_memband             arr_rdata;
    logic                    last_busy;

    // Final BUSY cycle: the array access happens on the edge leaving it
    assign last_busy = (state_q == BUSY) && (cnt_q == '0);
    // Reset blocks the commit so an aborted write never lands
    assign arr_we    = last_busy && write_op_q && !reset;

    lc3b_pmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (addr_q[DEPTH_LOG2+3:4]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Next-state, latch capture, counter and protocol-error detection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_op_d = write_op_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (pmem.pmem_read || pmem.pmem_write) begin
                    addr_d     = pmem.pmem_address;
                    wdata_d    = pmem.pmem_wdata;
                    write_op_d = pmem.pmem_write;
                    cnt_d      = CNT_LOAD;
                    state_d    = BUSY;
                    if (pmem.pmem_read && pmem.pmem_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Requester must hold the request and its operands steady
                if (!(pmem.pmem_read || pmem.pmem_write) ||
                    (pmem.pmem_address != addr_q) ||
                    (pmem.pmem_wdata != wdata_q)) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!write_op_q) begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_op_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_op_q <= write_op_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign pmem.pmem_resp  = (state_q == RESP);
    assign pmem.pmem_rdata = rdata_q;
    assign pmem.pmem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_pmem_responder
// Description : Directed self-checking bench: default instance, LATENCY=2
//               instance and DEPTH_LOG2=4 instance sharing one stimulus bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lc3b_pmem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3b_pmem_responder_if a_if ();
    lc3b_pmem_responder_if b_if ();
    lc3b_pmem_responder_if c_if ();

    lc3b_pmem_responder #(.LATENCY(8), .DEPTH_LOG2(12)) u_a (.clk(clk), .reset(reset), .pmem(a_if));
    lc3b_pmem_responder #(.LATENCY(2), .DEPTH_LOG2(12)) u_b (.clk(clk), .reset(reset), .pmem(b_if));
    lc3b_pmem_responder #(.LATENCY(8), .DEPTH_LOG2(4))  u_c (.clk(clk), .reset(reset), .pmem(c_if));

    logic        t_read, t_write;
    lc3b_word    t_addr;
    lc3b_memband t_wdata;
    int          sel;

    assign a_if.pmem_read    = t_read  && (sel == 0);
    assign a_if.pmem_write   = t_write && (sel == 0);
    assign a_if.pmem_address = t_addr;
    assign a_if.pmem_wdata   = t_wdata;
    assign b_if.pmem_read    = t_read  && (sel == 1);
    assign b_if.pmem_write   = t_write && (sel == 1);
    assign b_if.pmem_address = t_addr;
    assign b_if.pmem_wdata   = t_wdata;
    assign c_if.pmem_read    = t_read  && (sel == 2);
    assign c_if.pmem_write   = t_write && (sel == 2);
    assign c_if.pmem_address = t_addr;
    assign c_if.pmem_wdata   = t_wdata;

    logic        o_resp, o_err;
    lc3b_memband o_rdata;
    always_comb begin
        o_resp  = a_if.pmem_resp;
        o_err   = a_if.pmem_err;
        o_rdata = a_if.pmem_rdata;
        case (sel)
            1: begin o_resp = b_if.pmem_resp; o_err = b_if.pmem_err; o_rdata = b_if.pmem_rdata; end
            2: begin o_resp = c_if.pmem_resp; o_err = c_if.pmem_err; o_rdata = c_if.pmem_rdata; end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    localparam lc3b_memband LINE_D = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam lc3b_memband LINE_P = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    localparam lc3b_memband LINE_Q = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam lc3b_memband LINE_X = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

    // Issue one request at cycle 0; keep it held until hold_n responses seen
    task automatic txn(input logic rd, input logic wr, input lc3b_word addr,
                       input lc3b_memband wd, input int hold_n,
                       output int c1, output int c2, output int n,
                       output lc3b_memband rd_first);
        @(negedge clk);
        t_read = rd; t_write = wr; t_addr = addr; t_wdata = wd;
        c1 = -1; c2 = -1; n = 0; rd_first = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (o_resp) begin
                n++;
                if (n == 1) begin
                    c1 = c;
                    rd_first = o_rdata;
                end else if (n == 2) begin
                    c2 = c;
                end
                if (n == hold_n) begin
                    t_read = 1'b0; t_write = 1'b0;
                end
            end
        end
        t_read = 1'b0; t_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        t_read = 1'b0; t_write = 1'b0; t_addr = '0; t_wdata = '0; sel = 0;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL reset_resp inst%0d got %b want 0", s, o_resp); end
            checks++; if (o_rdata !== '0) begin errors++; $display("FAIL reset_rdata inst%0d got %h want 0", s, o_rdata); end
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err inst%0d got %b want 0", s, o_err); end
        end
        sel = 0;
    endtask

    task automatic test_reset_read();
        int c1, c2, n; lc3b_memband r;
        sel = 0;
        txn(1'b1, 1'b0, 16'h0000, '0, 1, c1, c2, n, r);
        checks++; if (c1 !== 8) begin errors++; $display("FAIL rr_latency got %0d want 8", c1); end
        checks++; if (n !== 1) begin errors++; $display("FAIL rr_resp_count got %0d want 1", n); end
        checks++; if (r !== '0) begin errors++; $display("FAIL rr_rdata got %h want 0", r); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rr_err got %b want 0", o_err); end
    endtask

    task automatic test_write_read();
        int c1, c2, n; lc3b_memband r;
        sel = 0;
        txn(1'b0, 1'b1, 16'h1A30, LINE_D, 1, c1, c2, n, r);
        checks++; if (c1 !== 8 || n !== 1) begin errors++; $display("FAIL wr_resp got c%0d n%0d want c8 n1", c1, n); end
        txn(1'b1, 1'b0, 16'h1A3F, '0, 1, c1, c2, n, r);
        checks++; if (r !== LINE_D) begin errors++; $display("FAIL wr_readback got %h want %h", r, LINE_D); end
        // A write must not disturb the held read data
        txn(1'b0, 1'b1, 16'h1A50, LINE_Q, 1, c1, c2, n, r);
        checks++; if (o_rdata !== LINE_D) begin errors++; $display("FAIL rdata_hold got %h want %h", o_rdata, LINE_D); end
        txn(1'b1, 1'b0, 16'h1A40, '0, 1, c1, c2, n, r);
        checks++; if (r !== '0) begin errors++; $display("FAIL wr_neighbour got %h want 0", r); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", o_err); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, n; lc3b_memband r;
        sel = 0;
        txn(1'b1, 1'b0, 16'h1A30, '0, 2, c1, c2, n, r);
        checks++; if (c1 !== 8 || c2 !== 17) begin errors++; $display("FAIL b2b_cycles got %0d,%0d want 8,17", c1, c2); end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n); end
        checks++; if (o_rdata !== LINE_D) begin errors++; $display("FAIL b2b_rdata got %h want %h", o_rdata, LINE_D); end
        sel = 1;
        txn(1'b1, 1'b0, 16'h0000, '0, 2, c1, c2, n, r);
        checks++; if (c1 !== 2 || c2 !== 5) begin errors++; $display("FAIL b2b_lat2_cycles got %0d,%0d want 2,5", c1, c2); end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_lat2_count got %0d want 2", n); end
        sel = 0;
    endtask

    task automatic test_protocol_error();
        int c1, c2, n; lc3b_memband r;
        sel = 0;
        txn(1'b1, 1'b1, 16'h0200, {128{1'b1}}, 1, c1, c2, n, r);
        checks++; if (c1 !== 8) begin errors++; $display("FAIL perr_latency got %0d want 8", c1); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL perr_flag got %b want 1", o_err); end
        txn(1'b1, 1'b0, 16'h0200, '0, 1, c1, c2, n, r);
        checks++; if (r !== {128{1'b1}}) begin errors++; $display("FAIL perr_readback got %h want all-ones", r); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b want 1", o_err); end
    endtask

    task automatic test_reset_mid_write();
        int c1, c2, n; lc3b_memband r;
        int nresp;
        sel = 0;
        txn(1'b0, 1'b1, 16'h0400, LINE_P, 1, c1, c2, n, r);
        nresp = 0;
        @(negedge clk);
        t_write = 1'b1; t_addr = 16'h0400; t_wdata = LINE_Q;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (o_resp) nresp++;
        end
        reset = 1'b1; t_write = 1'b0;
        @(posedge clk); #1;
        if (o_resp) nresp++;
        reset = 1'b0;
        for (int c = 6; c <= 25; c++) begin
            @(posedge clk); #1;
            if (o_resp) nresp++;
        end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL abort_resp got %0d want 0", nresp); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL abort_err_clear got %b want 0", o_err); end
        txn(1'b1, 1'b0, 16'h0400, '0, 1, c1, c2, n, r);
        checks++; if (r !== LINE_P) begin errors++; $display("FAIL abort_readback got %h want %h", r, LINE_P); end
    endtask

    task automatic test_alias();
        int c1, c2, n; lc3b_memband r;
        sel = 2;
        txn(1'b0, 1'b1, 16'h0010, LINE_X, 1, c1, c2, n, r);
        txn(1'b1, 1'b0, 16'h0110, '0, 1, c1, c2, n, r);
        checks++; if (r !== LINE_X) begin errors++; $display("FAIL alias_read got %h want %h", r, LINE_X); end
        txn(1'b1, 1'b0, 16'h0020, '0, 1, c1, c2, n, r);
        checks++; if (r !== '0) begin errors++; $display("FAIL alias_other got %h want 0", r); end
        sel = 0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_reset_read();
        test_write_read();
        test_back_to_back();
        test_protocol_error();
        test_reset_mid_write();
        test_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
